// File: rtl/decode_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// decode_sequencer_pkg
// Shared types and constants for the JPEG decode sequencer:
//   - SRAM port widths and the watchdog counter width
//   - default stage timeout
//   - seq_states: sequencer state encoding (also the externally visible Stage)
//   - seq_regs_t / regs_for(): the registered FSM outputs implied by a state
// -----------------------------------------------------------------------------
package decode_sequencer_pkg;

   localparam int ADDR_W = 18;
   localparam int DATA_W = 16;
   localparam int WDOG_W = 24;

   localparam logic [WDOG_W-1:0] DEFAULT_TIMEOUT_CYCLES = 24'd8_000_000;

   typedef enum logic [2:0] {
      S_SEQ_IDLE  = 3'd0,
      S_SEQ_M3    = 3'd1,
      S_SEQ_M2    = 3'd2,
      S_SEQ_M1    = 3'd3,
      S_SEQ_GAP   = 3'd4,
      S_SEQ_DONE  = 3'd5,
      S_SEQ_ERROR = 3'd6
   } seq_states;

   // State plus every output that is a pure function of it, so that one
   // registered assignment keeps state and outputs in lock-step.
   typedef struct packed {
      seq_states state;
      logic      m3_en;
      logic      m2_en;
      logic      m1_en;
      logic      busy;
      logic      done;
      logic      error;
   } seq_regs_t;

   function automatic seq_regs_t regs_for(input seq_states s);
      seq_regs_t r;
      r.state = s;
      r.m3_en = (s == S_SEQ_M3);
      r.m2_en = (s == S_SEQ_M2);
      r.m1_en = (s == S_SEQ_M1);
      r.busy  = (s == S_SEQ_M3) || (s == S_SEQ_M2) || (s == S_SEQ_M1) || (s == S_SEQ_GAP);
      r.done  = (s == S_SEQ_DONE);
      r.error = (s == S_SEQ_ERROR);
      return r;
   endfunction

endpackage

// File: rtl/decode_sequencer_if.sv
// -----------------------------------------------------------------------------
// decode_sequencer_if
// Bundles the sequencer's control handshakes and SRAM agent buses.
//   master : the sequencer side (drives Enables, status, muxed SRAM port)
//   slave  : the environment side (Start/Skip_Mask, stage Stops, agent buses)
// Signals:
//   Start, Skip_Mask[2:0]          run request and stage skip mask
//   M3/M2/M1_Enable, _Stop         per-stage level handshake
//   <agent>_SRAM_address/_write_data/_we_n  for UART, M3, M2, M1
//   VGA_SRAM_address               display read address
//   SRAM_address/_write_data/_we_n granted SRAM port
//   Busy, Done, Error, Stage[2:0]  status
// -----------------------------------------------------------------------------
interface decode_sequencer_if;
   import decode_sequencer_pkg::*;

   logic              Start;
   logic [2:0]        Skip_Mask;

   logic              M3_Enable, M2_Enable, M1_Enable;
   logic              M3_Stop,   M2_Stop,   M1_Stop;

   logic [ADDR_W-1:0] UART_SRAM_address, M3_SRAM_address, M2_SRAM_address, M1_SRAM_address;
   logic [DATA_W-1:0] UART_SRAM_write_data, M3_SRAM_write_data, M2_SRAM_write_data, M1_SRAM_write_data;
   logic              UART_SRAM_we_n, M3_SRAM_we_n, M2_SRAM_we_n, M1_SRAM_we_n;
   logic [ADDR_W-1:0] VGA_SRAM_address;

   logic [ADDR_W-1:0] SRAM_address;
   logic [DATA_W-1:0] SRAM_write_data;
   logic              SRAM_we_n;

   logic              Busy, Done, Error;
   logic [2:0]        Stage;

   modport master (
      input  Start, Skip_Mask,
      input  M3_Stop, M2_Stop, M1_Stop,
      input  UART_SRAM_address, M3_SRAM_address, M2_SRAM_address, M1_SRAM_address,
      input  UART_SRAM_write_data, M3_SRAM_write_data, M2_SRAM_write_data, M1_SRAM_write_data,
      input  UART_SRAM_we_n, M3_SRAM_we_n, M2_SRAM_we_n, M1_SRAM_we_n,
      input  VGA_SRAM_address,
      output M3_Enable, M2_Enable, M1_Enable,
      output SRAM_address, SRAM_write_data, SRAM_we_n,
      output Busy, Done, Error, Stage
   );

   modport slave (
      output Start, Skip_Mask,
      output M3_Stop, M2_Stop, M1_Stop,
      output UART_SRAM_address, M3_SRAM_address, M2_SRAM_address, M1_SRAM_address,
      output UART_SRAM_write_data, M3_SRAM_write_data, M2_SRAM_write_data, M1_SRAM_write_data,
      output UART_SRAM_we_n, M3_SRAM_we_n, M2_SRAM_we_n, M1_SRAM_we_n,
      output VGA_SRAM_address,
      input  M3_Enable, M2_Enable, M1_Enable,
      input  SRAM_address, SRAM_write_data, SRAM_we_n,
      input  Busy, Done, Error, Stage
   );

endinterface

// File: rtl/decode_sequencer_stage_watchdog.sv
// -----------------------------------------------------------------------------
// stage_watchdog
// Cycle counter that flags a stage which has run too long.
// Ports:
//   Clock, Resetn  clock, asynchronous active-low reset
//   clear          force the count to 0 (held while no stage is running)
//   count_en       a stage is running; count this cycle
//   expired        count_en and count == TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module stage_watchdog
   import decode_sequencer_pkg::*;
#(
   parameter logic [WDOG_W-1:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic Clock,
   input  logic Resetn,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   logic [WDOG_W-1:0] count;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (count_en) begin
         count <= count + 1'b1;
      end
   end

   // Count k during the k-th cycle (from 0) of a stage, so the stage is
   // aborted at the end of its TIMEOUT_CYCLES-th cycle.
   assign expired = count_en && (count == TIMEOUT_CYCLES - 1'b1);

endmodule

// File: rtl/decode_sequencer.sv
// -----------------------------------------------------------------------------
// decode_sequencer
// Top-level JPEG decode sequencer. Runs M3 -> M2 -> M1 with level-held
// Enable/Stop handshakes, a one-cycle GAP between stages, a per-stage
// watchdog, and a combinational SRAM grant mux driven from registered state.
// Ports:
//   Clock   system clock (rising edge)
//   Resetn  asynchronous active-low reset
//   bus     decode_sequencer_if.master: Start/Skip_Mask, stage handshakes,
//           agent SRAM buses, granted SRAM port, Busy/Done/Error/Stage
// -----------------------------------------------------------------------------
module decode_sequencer
   import decode_sequencer_pkg::*;
#(
   parameter logic [WDOG_W-1:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic Clock,
   input  logic Resetn,
   decode_sequencer_if.master bus
);

   seq_regs_t  regs;
   seq_states  last_stage;   // stage just left, consulted in GAP
   logic [2:0] mask_q;
   logic       in_stage;
   logic       stop_active;
   logic       expired;

   // First non-skipped stage after 'after' in M3 -> M2 -> M1 order.
   // S_SEQ_IDLE stands for "before any stage".
   function automatic seq_states next_stage(input seq_states after, input logic [2:0] mask);
      if ((after == S_SEQ_IDLE) && !mask[0])
         return S_SEQ_M3;
      if (((after == S_SEQ_IDLE) || (after == S_SEQ_M3)) && !mask[1])
         return S_SEQ_M2;
      if (((after == S_SEQ_IDLE) || (after == S_SEQ_M3) || (after == S_SEQ_M2)) && !mask[2])
         return S_SEQ_M1;
      return S_SEQ_DONE;
   endfunction

   assign in_stage = (regs.state == S_SEQ_M3) || (regs.state == S_SEQ_M2) ||
                     (regs.state == S_SEQ_M1);

   // Only the active stage's Stop is listened to.
   always_comb begin
      stop_active = 1'b0;
      case (regs.state)
         S_SEQ_M3: stop_active = bus.M3_Stop;
         S_SEQ_M2: stop_active = bus.M2_Stop;
         S_SEQ_M1: stop_active = bus.M1_Stop;
         default:  stop_active = 1'b0;
      endcase
   end

   // Held clear outside stages; every stage is entered from a non-stage
   // state, so the count always starts from 0.
   stage_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .Clock    (Clock),
      .Resetn   (Resetn),
      .clear    (!in_stage),
      .count_en (in_stage),
      .expired  (expired)
   );

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         regs       <= regs_for(S_SEQ_IDLE);
         last_stage <= S_SEQ_IDLE;
         mask_q     <= '0;
      end else begin
         case (regs.state)
            S_SEQ_IDLE, S_SEQ_DONE, S_SEQ_ERROR: begin
               if (bus.Start) begin
                  mask_q <= bus.Skip_Mask;
                  regs   <= regs_for(next_stage(S_SEQ_IDLE, bus.Skip_Mask));
               end
            end
            S_SEQ_M3, S_SEQ_M2, S_SEQ_M1: begin
               // Stop takes priority over a simultaneous timeout.
               if (stop_active) begin
                  last_stage <= regs.state;
                  regs       <= regs_for(S_SEQ_GAP);
               end else if (expired) begin
                  regs <= regs_for(S_SEQ_ERROR);
               end
            end
            S_SEQ_GAP: begin
               regs <= regs_for(next_stage(last_stage, mask_q));
            end
            default: begin
               regs <= regs_for(S_SEQ_IDLE);
            end
         endcase
      end
   end

   assign bus.M3_Enable = regs.m3_en;
   assign bus.M2_Enable = regs.m2_en;
   assign bus.M1_Enable = regs.m1_en;
   assign bus.Busy      = regs.busy;
   assign bus.Done      = regs.done;
   assign bus.Error     = regs.error;
   assign bus.Stage     = regs.state;

   // SRAM grant: no pipeline stage here, owners register their own outputs.
   always_comb begin
      bus.SRAM_address    = '0;
      bus.SRAM_write_data = '0;
      bus.SRAM_we_n       = 1'b1;
      case (regs.state)
         S_SEQ_IDLE: begin
            bus.SRAM_address    = bus.UART_SRAM_address;
            bus.SRAM_write_data = bus.UART_SRAM_write_data;
            bus.SRAM_we_n       = bus.UART_SRAM_we_n;
         end
         S_SEQ_M3: begin
            bus.SRAM_address    = bus.M3_SRAM_address;
            bus.SRAM_write_data = bus.M3_SRAM_write_data;
            bus.SRAM_we_n       = bus.M3_SRAM_we_n;
         end
         S_SEQ_M2: begin
            bus.SRAM_address    = bus.M2_SRAM_address;
            bus.SRAM_write_data = bus.M2_SRAM_write_data;
            bus.SRAM_we_n       = bus.M2_SRAM_we_n;
         end
         S_SEQ_M1: begin
            bus.SRAM_address    = bus.M1_SRAM_address;
            bus.SRAM_write_data = bus.M1_SRAM_write_data;
            bus.SRAM_we_n       = bus.M1_SRAM_we_n;
         end
         S_SEQ_DONE: begin
            bus.SRAM_address    = bus.VGA_SRAM_address;
         end
         default: begin
            // GAP and ERROR park the port with writes disabled.
            bus.SRAM_address    = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_decode_sequencer.sv
// -----------------------------------------------------------------------------
// tb_decode_sequencer
// Randomized bench for decode_sequencer. Stage stubs raise Stop after a
// chosen number of Enable-high cycles (0 = never). For each run the bench
// derives the expected per-cycle Stage trace from the mask and latencies and
// compares Stage, Enables, status flags and the SRAM grant every cycle.
// -----------------------------------------------------------------------------
module tb_decode_sequencer;
   import decode_sequencer_pkg::*;

   localparam int TMO = 100;

   logic Clock  = 1'b0;
   logic Resetn = 1'b0;

   decode_sequencer_if bus ();

   decode_sequencer #(
      .TIMEOUT_CYCLES (24'(TMO))
   ) dut (
      .Clock  (Clock),
      .Resetn (Resetn),
      .bus    (bus.master)
   );

   always #5 Clock = ~Clock;

   int errors = 0;
   int checks = 0;
   int lat [3];
   bit noise;
   int hi [3];
   bit was [3];
   int exp_q [$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   // Granted port as {address, write_data, we_n} for the owner of stage st.
   function automatic logic [34:0] sram_model(input int st);
      case (st)
         0:       return {bus.UART_SRAM_address, bus.UART_SRAM_write_data, bus.UART_SRAM_we_n};
         1:       return {bus.M3_SRAM_address, bus.M3_SRAM_write_data, bus.M3_SRAM_we_n};
         2:       return {bus.M2_SRAM_address, bus.M2_SRAM_write_data, bus.M2_SRAM_we_n};
         3:       return {bus.M1_SRAM_address, bus.M1_SRAM_write_data, bus.M1_SRAM_we_n};
         5:       return {bus.VGA_SRAM_address, 16'd0, 1'b1};
         default: return {18'd0, 16'd0, 1'b1};
      endcase
   endfunction

   // Called on the falling edge: update stage stubs and randomize agent buses.
   task automatic drive_stubs(input bit allow_start);
      bit en [3];
      bit st [3];
      en[0] = bus.M3_Enable;
      en[1] = bus.M2_Enable;
      en[2] = bus.M1_Enable;
      for (int i = 0; i < 3; i++) begin
         if (en[i]) hi[i] = was[i] ? hi[i] + 1 : 0;
         was[i] = en[i];
         if (en[i]) st[i] = (lat[i] != 0) && (hi[i] == lat[i] - 1);
         else       st[i] = noise && ($urandom_range(0, 3) == 0);
      end
      bus.M3_Stop              = st[0];
      bus.M2_Stop              = st[1];
      bus.M1_Stop              = st[2];
      bus.UART_SRAM_address    = 18'($urandom);
      bus.M3_SRAM_address      = 18'($urandom);
      bus.M2_SRAM_address      = 18'($urandom);
      bus.M1_SRAM_address      = 18'($urandom);
      bus.VGA_SRAM_address     = 18'($urandom);
      bus.UART_SRAM_write_data = 16'($urandom);
      bus.M3_SRAM_write_data   = 16'($urandom);
      bus.M2_SRAM_write_data   = 16'($urandom);
      bus.M1_SRAM_write_data   = 16'($urandom);
      // Writes mostly enabled so a forced we_n=1 is visible.
      bus.UART_SRAM_we_n       = ($urandom_range(0, 3) == 0);
      bus.M3_SRAM_we_n         = ($urandom_range(0, 3) == 0);
      bus.M2_SRAM_we_n         = ($urandom_range(0, 3) == 0);
      bus.M1_SRAM_we_n         = ($urandom_range(0, 3) == 0);
      bus.Skip_Mask            = 3'($urandom);
      bus.Start                = allow_start && noise && ($urandom_range(0, 7) == 0);
   endtask

   task automatic check_cycle(input int st, input string tag);
      chk({tag, ".stage"}, 64'(bus.Stage), 64'(st));
      chk({tag, ".enables"}, 64'({bus.M3_Enable, bus.M2_Enable, bus.M1_Enable}),
          64'({st == 1, st == 2, st == 3}));
      chk({tag, ".flags"}, 64'({bus.Busy, bus.Done, bus.Error}),
          64'({(st >= 1 && st <= 4), st == 5, st == 6}));
      chk({tag, ".sram"}, 64'({bus.SRAM_address, bus.SRAM_write_data, bus.SRAM_we_n}),
          64'(sram_model(st)));
   endtask

   // One decode run: Start with mask, stubs stop after l3/l2/l1 cycles.
   task automatic run(input logic [2:0] mask, input int l3, input int l2, input int l1,
                      input bit nz, input string name);
      bit err;
      int fin;
      lat[0] = l3;
      lat[1] = l2;
      lat[2] = l1;
      noise  = nz;
      err    = 1'b0;
      exp_q.delete();
      for (int s = 0; s < 3; s++) begin
         if (!mask[s]) begin
            if (lat[s] == 0) begin
               repeat (TMO) exp_q.push_back(s + 1);
               exp_q.push_back(6);
               err = 1'b1;
               break;
            end
            repeat (lat[s]) exp_q.push_back(s + 1);
            exp_q.push_back(4);
         end
      end
      if (!err) exp_q.push_back(5);
      fin = exp_q[exp_q.size() - 1];

      @(negedge Clock);
      drive_stubs(1'b0);
      bus.Skip_Mask = mask;
      bus.Start     = 1'b1;
      foreach (exp_q[i]) begin
         @(negedge Clock);
         drive_stubs(exp_q[i] >= 1 && exp_q[i] <= 4);
         #1 check_cycle(exp_q[i], name);
      end
      @(negedge Clock);
      drive_stubs(1'b0);
      #1 check_cycle(fin, {name, ".hold"});
   endtask

   function automatic int pick_lat();
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) return 0;
      if (r == 1) return TMO;
      return $urandom_range(1, 20);
   endfunction

   initial begin
      bus.Start     = 1'b0;
      bus.Skip_Mask = 3'b000;
      noise         = 1'b0;
      for (int i = 0; i < 3; i++) begin
         lat[i] = 0;
         hi[i]  = 0;
         was[i] = 1'b0;
      end

      repeat (2) @(negedge Clock);
      drive_stubs(1'b0);
      #1 check_cycle(0, "reset");
      @(negedge Clock);
      Resetn = 1'b1;
      drive_stubs(1'b0);
      #1 check_cycle(0, "idle");

      run(3'b000, 10, 10, 10, 1'b0, "seq10");
      run(3'b011, 5, 5, 7, 1'b1, "m1only");
      run(3'b000, 3, 0, 4, 1'b0, "timeout");
      run(3'b000, 2, 2, 2, 1'b0, "restart");
      run(3'b000, 1, 1, 1, 1'b0, "min7");
      run(3'b000, 4, TMO, 3, 1'b0, "stopwins");
      run(3'b111, 1, 1, 1, 1'b1, "allskip");

      // Asynchronous reset in the middle of M1.
      lat[0] = 0; lat[1] = 0; lat[2] = 0;
      noise  = 1'b0;
      @(negedge Clock);
      drive_stubs(1'b0);
      bus.Skip_Mask = 3'b011;
      bus.Start     = 1'b1;
      repeat (5) begin
         @(negedge Clock);
         drive_stubs(1'b0);
      end
      #1 check_cycle(3, "pre_rst");
      Resetn = 1'b0;
      #1 check_cycle(0, "async_rst");
      @(negedge Clock);
      drive_stubs(1'b0);
      Resetn = 1'b1;
      #1 check_cycle(0, "post_rst");

      for (int n = 0; n < 25; n++) begin
         run(3'($urandom), pick_lat(), pick_lat(), pick_lat(), 1'b1, "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
